// File: rtl/ram_arbiter_pkg.sv
// Shared defaults and FSM encoding for the RAM arbiter.
package ram_arbiter_pkg;

    localparam int unsigned DefAddrW = 5;
    localparam int unsigned DefDataW = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin selector: searches upward from the requester after last_grant.
module rr_pick #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IdxW-1:0] last_grant,
    output logic [NREQ-1:0] grant
);

    logic            found;
    logic [IdxW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IdxW'((32'(last_grant) + k) % NREQ);
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates NREQ requesters onto one external synchronous RAM, one transaction per 3 cycles.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]      resp_rdata,
    output logic                   ram_cs,
    output logic                   ram_we,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [DATA_W-1:0]      ram_in,
    input  logic [DATA_W-1:0]      ram_out
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   grant_q, grant_d;
    logic [IdxW-1:0]   last_grant_q, last_grant_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [NREQ-1:0]   grant_oh;
    logic [IdxW-1:0]   grant_idx;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_pick #(
        .NREQ (NREQ),
        .IdxW (IdxW)
    ) u_rr_pick (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant_oh)
    );

    // Mux the winner's request fields out of the packed buses.
    always_comb begin
        grant_idx = '0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_oh[i]) begin
                grant_idx = IdxW'(i);
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        req_ready    = '0;
        unique case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    req_ready    = grant_oh;
                    state_d      = StAccess;
                    grant_d      = grant_idx;
                    last_grant_d = grant_idx;
                    write_d      = sel_write;
                    addr_d       = sel_addr;
                    wdata_d      = sel_wdata;
                end
            end
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= IdxW'(NREQ - 1);
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // RAM and response outputs decode only registered state, so reset clears them at once.
    always_comb begin
        ram_cs     = (state_q == StAccess);
        ram_we     = ram_cs & write_q;
        ram_addr   = ram_cs ? addr_q : '0;
        ram_in     = ram_cs ? wdata_q : '0;
        resp_rdata = (state_q == StResp) ? ram_out : '0;
        resp_valid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            resp_valid[i] = (state_q == StResp) && (grant_q == IdxW'(i));
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 32x8 registered-read RAM.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_write;
    logic [9:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_ready, resp_valid;
    logic [7:0]  resp_rdata;
    logic        ram_cs, ram_we;
    logic [4:0]  ram_addr;
    logic [7:0]  ram_in;
    logic [7:0]  ram_out;

    logic [7:0]  mem [32];
    logic        mem_init = 1'b0;

    int checks   = 0;
    int failures = 0;

    ram_arbiter #(
        .NREQ   (2),
        .ADDR_W (5),
        .DATA_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .ram_cs     (ram_cs),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_in     (ram_in),
        .ram_out    (ram_out)
    );

    always #5 clk = ~clk;

    // Memory preloads to 0x40+addr on the first edge; write-through on writes.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h40 + 8'(i);
            mem_init <= 1'b1;
            ram_out  <= 8'h00;
        end else if (ram_cs) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_in;
                ram_out       <= ram_in;
            end else begin
                ram_out <= mem[ram_addr];
            end
        end
    end

    // {req_ready, resp_valid, resp_rdata, ram_cs, ram_we, ram_addr, ram_in}
    function automatic logic [26:0] pk(logic [1:0] rdy, logic [1:0] rv, logic [7:0] rd,
                                       logic cs, logic we, logic [4:0] a, logic [7:0] d);
        return {rdy, rv, rd, cs, we, a, d};
    endfunction

    task automatic chk(input string name, input logic [26:0] exp);
        logic [26:0] act;
        act = {req_ready, resp_valid, resp_rdata, ram_cs, ram_we, ram_addr, ram_in};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got rdy=%b rv=%b rd=%h cs=%b we=%b a=%0d in=%h, expected rdy=%b rv=%b rd=%h cs=%b we=%b a=%0d in=%h",
                     name, act[26:25], act[24:23], act[22:15], act[14], act[13], act[12:8],
                     act[7:0], exp[26:25], exp[24:23], exp[22:15], exp[14], exp[13], exp[12:8],
                     exp[7:0]);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [4:0] a0,
                         input logic [4:0] a1, input logic [7:0] d0, input logic [7:0] d1);
        req_valid = v;
        req_write = w;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] valid;
        logic [1:0] write;
        logic [4:0] a0, a1;
        logic [7:0] d0, d1;
        logic [1:0] exp_ready;
        logic       exp_we;
        logic [4:0] exp_addr;
        logic [7:0] exp_in;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [1:0] oh;

        // Single requesters, then contention where the loser withdraws after the grant.
        vecs[0] = '{2'b01, 2'b01, 5'd5,  5'd0,  8'hA5, 8'h00, 2'b01, 1'b1, 5'd5,  8'hA5, 8'hA5};
        vecs[1] = '{2'b10, 2'b00, 5'd0,  5'd5,  8'h00, 8'h77, 2'b10, 1'b0, 5'd5,  8'h77, 8'hA5};
        vecs[2] = '{2'b01, 2'b01, 5'd31, 5'd0,  8'hFF, 8'h00, 2'b01, 1'b1, 5'd31, 8'hFF, 8'hFF};
        vecs[3] = '{2'b10, 2'b00, 5'd0,  5'd31, 8'h00, 8'h00, 2'b10, 1'b0, 5'd31, 8'h00, 8'hFF};
        vecs[4] = '{2'b11, 2'b10, 5'd7,  5'd8,  8'h11, 8'hEE, 2'b01, 1'b0, 5'd7,  8'h11, 8'h47};
        vecs[5] = '{2'b11, 2'b10, 5'd10, 5'd9,  8'h22, 8'h5A, 2'b10, 1'b1, 5'd9,  8'h5A, 8'h5A};
        vecs[6] = '{2'b10, 2'b00, 5'd0,  5'd8,  8'h00, 8'h00, 2'b10, 1'b0, 5'd8,  8'h00, 8'h48};

        rst_n = 1'b0;
        drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        #1;
        chk("reset_outputs", pk(2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Simultaneous first requests: requester 0 wins, requester 1 keeps waiting.
        drive(2'b11, 2'b10, 5'd3, 5'd3, 8'h00, 8'h3C);
        @(negedge clk); chk("contend_ready0", pk(2'b01, 2'b00, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00));
        next_cycle();
        drive(2'b10, 2'b10, 5'd0, 5'd3, 8'h00, 8'h3C);
        @(negedge clk); chk("contend_access0", pk(2'b00, 2'b00, 8'h00, 1'b1, 1'b0, 5'd3, 8'h00));
        next_cycle();
        @(negedge clk); chk("contend_resp0", pk(2'b00, 2'b01, 8'h43, 1'b0, 1'b0, 5'd0, 8'h00));
        next_cycle();
        @(negedge clk); chk("contend_ready1", pk(2'b10, 2'b00, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00));
        next_cycle();
        drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        @(negedge clk); chk("contend_access1", pk(2'b00, 2'b00, 8'h00, 1'b1, 1'b1, 5'd3, 8'h3C));
        next_cycle();
        @(negedge clk); chk("contend_resp1", pk(2'b00, 2'b10, 8'h3C, 1'b0, 1'b0, 5'd0, 8'h00));
        next_cycle();

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].valid, vecs[i].write, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            @(negedge clk);
            chk($sformatf("vec%0d_idle", i),
                pk(vecs[i].exp_ready, 2'b00, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00));
            next_cycle();
            drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
            @(negedge clk);
            chk($sformatf("vec%0d_access", i),
                pk(2'b00, 2'b00, 8'h00, 1'b1, vecs[i].exp_we, vecs[i].exp_addr, vecs[i].exp_in));
            next_cycle();
            @(negedge clk);
            chk($sformatf("vec%0d_resp", i),
                pk(2'b00, vecs[i].exp_ready, vecs[i].exp_rdata, 1'b0, 1'b0, 5'd0, 8'h00));
            next_cycle();
        end

        @(negedge clk); chk("idle_quiet", pk(2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00));
        next_cycle();

        // Both requesters held valid: grants must alternate.
        drive(2'b11, 2'b00, 5'd0, 5'd1, 8'h00, 8'h00);
        for (int t = 0; t < 6; t++) begin
            oh = (t % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            chk($sformatf("rr%0d_idle", t), pk(oh, 2'b00, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00));
            next_cycle();
            @(negedge clk);
            chk($sformatf("rr%0d_access", t),
                pk(2'b00, 2'b00, 8'h00, 1'b1, 1'b0, 5'(t % 2), 8'h00));
            next_cycle();
            @(negedge clk);
            chk($sformatf("rr%0d_resp", t),
                pk(2'b00, oh, 8'h40 + 8'(t % 2), 1'b0, 1'b0, 5'd0, 8'h00));
            next_cycle();
        end
        drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);

        // Reset asserted mid-ACCESS aborts the write with no response.
        drive(2'b01, 2'b01, 5'd12, 5'd0, 8'h99, 8'h00);
        @(negedge clk); chk("abort_ready", pk(2'b01, 2'b00, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00));
        next_cycle();
        drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        chk("abort_access", pk(2'b00, 2'b00, 8'h00, 1'b1, 1'b1, 5'd12, 8'h99));
        rst_n = 1'b0;
        #1;
        chk("abort_reset_now", pk(2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00));
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk); chk("abort_no_resp0", pk(2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00));
        next_cycle();
        @(negedge clk); chk("abort_no_resp1", pk(2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00));
        next_cycle();

        // last_grant returns to 1 on reset, so requester 0 wins this contention.
        drive(2'b11, 2'b00, 5'd3, 5'd5, 8'h00, 8'h00);
        @(negedge clk); chk("post_rst_ready", pk(2'b01, 2'b00, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00));
        next_cycle();
        drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        @(negedge clk); chk("post_rst_access", pk(2'b00, 2'b00, 8'h00, 1'b1, 1'b0, 5'd3, 8'h00));
        next_cycle();
        @(negedge clk); chk("post_rst_resp", pk(2'b00, 2'b01, 8'h3C, 1'b0, 1'b0, 5'd0, 8'h00));
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
